// File: rtl/instruction_loader.sv
// instruction_loader
//
// Writes a program image into the RAM-backed instruction memory from a framed
// byte stream (UART receiver / debug port). Bytes are packed big-endian into
// 32-bit words and each completed word produces a one-cycle write strobe.
// The CPU is held in reset while a frame is being loaded.
//
// Frame: START_BYTE, count N (0 = 256 words), N*4 data bytes,
//        [checksum byte = XOR of all data bytes, LOADER_CHECKSUM_EN only]
//
// Build option:
//   LOADER_CHECKSUM_EN  - adds the CHECK/ERROR states and the XOR checksum.
//                         Undefined: DATA ends directly in DONE and
//                         load_error is tied low.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in_data     received byte
//   in_valid    in_data valid
//   in_ready    loader can take a byte (transfer = in_valid && in_ready)
//   rearm       one-cycle pulse, DONE/ERROR -> IDLE
//   imem_we     one-cycle write strobe
//   imem_addr   byte address of the word ({word_idx, 2'b00})
//   imem_wdata  word to write
//   cpu_hold    keeps the CPU in reset
//   load_done   image written (and checksum matched)
//   load_error  checksum mismatch
module instruction_loader #(
    parameter logic [7:0] START_BYTE = 8'hA5,
    parameter int         DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rearm,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int AW = DEPTH_LOG2;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_DONE
    } state_t;
`endif

    // Status outputs are registered together with the state so they change
    // on the same edge as the state they describe.
    typedef struct packed {
        logic ready;
        logic hold;
        logic done;
`ifdef LOADER_CHECKSUM_EN
        logic err;
`endif
    } flags_t;

    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            S_IDLE:  f.ready = 1'b1;
            S_COUNT,
            S_DATA:  begin f.ready = 1'b1; f.hold = 1'b1; end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin f.ready = 1'b1; f.hold = 1'b1; end
            S_ERROR: begin f.hold  = 1'b1; f.err  = 1'b1; end
`endif
            S_DONE:  f.done = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    state_t        state;
    flags_t        flags;
    logic [7:0]    n_last;     // index of the final word (N-1, wraps so N=0 -> 255)
    logic [7:0]    word_cnt;   // words completed in this frame, for termination
    logic [AW-1:0] word_idx;   // write index, wraps modulo 2^DEPTH_LOG2
    logic [1:0]    byte_cnt;   // byte position within the current word
    logic [23:0]   asm_word;   // first three bytes of the word being assembled
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    xsum;
`endif

    logic accept;
    assign accept = in_valid && flags.ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            flags      <= flags_of(S_IDLE);
            n_last     <= '0;
            word_cnt   <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            xsum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Anything but the start marker is line noise; drop it.
                    if (accept && in_data == START_BYTE) begin
                        state <= S_COUNT;
                        flags <= flags_of(S_COUNT);
                    end
                end

                S_COUNT: begin
                    if (accept) begin
                        n_last   <= in_data - 8'd1;
                        word_cnt <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xsum     <= '0;
`endif
                        state    <= S_DATA;
                        flags    <= flags_of(S_DATA);
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        asm_word <= {asm_word[15:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        xsum     <= xsum ^ in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            // The word leaves the assembly register here, so
                            // the next byte can be taken during the write.
                            imem_we    <= 1'b1;
                            imem_wdata <= {asm_word, in_data};
                            imem_addr  <= 32'({word_idx, 2'b00});
                            word_idx   <= word_idx + AW'(1);
                            word_cnt   <= word_cnt + 8'd1;
                            if (word_cnt == n_last) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= S_CHECK;
                                flags <= flags_of(S_CHECK);
`else
                                state <= S_DONE;
                                flags <= flags_of(S_DONE);
`endif
                            end
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        if (in_data == xsum) begin
                            state <= S_DONE;
                            flags <= flags_of(S_DONE);
                        end else begin
                            state <= S_ERROR;
                            flags <= flags_of(S_ERROR);
                        end
                    end
                end

                S_ERROR: begin
                    if (rearm) begin
                        state <= S_IDLE;
                        flags <= flags_of(S_IDLE);
                    end
                end
`endif

                S_DONE: begin
                    if (rearm) begin
                        state <= S_IDLE;
                        flags <= flags_of(S_IDLE);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    flags <= flags_of(S_IDLE);
                end
            endcase
        end
    end

    assign in_ready  = flags.ready;
    assign cpu_hold  = flags.hold;
    assign load_done = flags.done;
`ifdef LOADER_CHECKSUM_EN
    assign load_error = flags.err;
`else
    assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    localparam logic [7:0] START = 8'hA5;
    localparam int         DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rearm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    instruction_loader #(.START_BYTE(START), .DEPTH_LOG2(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rearm(rearm), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef logic [7:0] bytes_t[$];

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic        we_prev  = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
`ifdef LOADER_CHECKSUM_EN
    int          csum_force = -1;   // -1: send the correct checksum
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: word k of the image is bytes 4k..4k+3, big-endian, at byte
    // address 4*(k mod 2^DEPTH).
    task automatic model_frame(input bytes_t d);
        wr_t w;
        for (int k = 0; k < d.size() / 4; k++) begin
            w.addr = 32'((k % (1 << DEPTH)) * 4);
            w.data = {d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]};
            exp_q.push_back(w);
        end
    endtask

    function automatic logic [7:0] xor_of(input bytes_t d);
        logic [7:0] x = 8'h00;
        foreach (d[i]) x ^= d[i];
        return x;
    endfunction

    // Every write the DUT makes must be the next one the model predicts.
    always @(negedge clk) begin : cmp
        wr_t e;
        if (!reset) begin
            we_prev = 1'b0;
        end else begin
            if (imem_we) begin
                n_writes++;
                last_addr = imem_addr;
                last_data = imem_wdata;
                check("we_single_cycle", {31'b0, we_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", imem_addr, e.addr);
                    check("write_data", imem_wdata, e.data);
                end
            end
            we_prev = imem_we;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        check("in_ready_when_sending", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_rearm();
        @(negedge clk);
        rearm = 1'b1;
        @(posedge clk);
        #1 rearm = 1'b0;
    endtask

    // mode 0: back-to-back; 1: valid every other cycle + 10-cycle stall
    // mid-word; 2: rearm pulse mid-frame (must be ignored)
    task automatic send_frame(input logic [7:0] cnt, input bytes_t d, input int mode);
        send_byte(START);
        check("cpu_hold_after_start", {31'b0, cpu_hold}, 32'd1);
        send_byte(cnt);
        if (mode == 2) pulse_rearm();
        for (int i = 0; i < d.size(); i++) begin
            if (mode == 1 && i == 6) repeat (10) @(posedge clk);
            send_byte(d[i]);
            if (i == d.size() - 1) begin
                check("last_we", {31'b0, imem_we}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
                check("done_before_csum", {31'b0, load_done}, 32'd0);
                check("hold_before_csum", {31'b0, cpu_hold}, 32'd1);
`else
                check("done_with_last_we", {31'b0, load_done}, 32'd1);
                check("hold_drop_with_done", {31'b0, cpu_hold}, 32'd0);
`endif
            end
            if (mode == 1) @(posedge clk);
        end
`ifdef LOADER_CHECKSUM_EN
        if (csum_force < 0) send_byte(xor_of(d));
        else                send_byte(8'(csum_force));
`endif
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_done(input string tag, input int writes_before, input int nw);
        check({tag, "_load_done"}, {31'b0, load_done}, 32'd1);
        check({tag, "_load_error"}, {31'b0, load_error}, 32'd0);
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_write_count"}, 32'(n_writes - writes_before), 32'(nw));
        check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {31'b0, imem_we}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'b0, load_done}, 32'd0);
        check({tag, "_error"}, {31'b0, load_error}, 32'd0);
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bytes_t prog, one, big;
        int     w0;

        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; rearm = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("in_reset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("after_reset");

        // Two-word image, back-to-back bytes.
        prog = '{8'h08, 8'h10, 8'h00, 8'h03, 8'h08, 8'h10, 8'h00, 8'h1F};
        model_frame(prog);
        check("model_w0_data", exp_q[0].data, 32'h08100003);
        check("model_w1_addr", exp_q[1].addr, 32'h4);
        check("model_xor", {24'b0, xor_of(prog)}, 32'h1C);
        w0 = n_writes;
        send_frame(8'h02, prog, 0);
        check_done("two_word", w0, 2);

        // rearm together with a byte: the byte is refused (in_ready was 0).
        @(negedge clk);
        rearm = 1'b1; in_valid = 1'b1; in_data = START;
        @(posedge clk);
        #1 begin rearm = 1'b0; in_valid = 1'b0; end
        @(posedge clk);
        #1;
        check("rearm_byte_dropped_hold", {31'b0, cpu_hold}, 32'd0);
        check("rearm_idle_ready", {31'b0, in_ready}, 32'd1);
        check("rearm_done_clear", {31'b0, load_done}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: both writes still happen, then ERROR.
        model_frame(prog);
        w0 = n_writes;
        csum_force = 0;
        send_frame(8'h02, prog, 0);
        csum_force = -1;
        check("err_load_error", {31'b0, load_error}, 32'd1);
        check("err_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("err_load_done", {31'b0, load_done}, 32'd0);
        check("err_in_ready", {31'b0, in_ready}, 32'd0);
        check("err_write_count", 32'(n_writes - w0), 32'd2);
        pulse_rearm();
        check("err_rearm_ready", {31'b0, in_ready}, 32'd1);
        check("err_rearm_clear", {31'b0, load_error}, 32'd0);
        check("err_rearm_hold", {31'b0, cpu_hold}, 32'd0);
`endif

        // Garbage in IDLE, then a 1-word frame whose data holds START values;
        // a rearm pulse mid-frame is ignored.
        w0 = n_writes;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        check("garbage_no_hold", {31'b0, cpu_hold}, 32'd0);
        one = '{START, START, 8'h00, 8'h01};
        model_frame(one);
        check("model_start_in_data", exp_q[0].data, 32'hA5A50001);
        send_frame(8'h01, one, 2);
        check_done("one_word", w0, 1);
        check("one_word_addr", last_addr, 32'h0);
        pulse_rearm();

        // Same image with toggled valid and a mid-word stall.
        model_frame(prog);
        w0 = n_writes;
        send_frame(8'h02, prog, 1);
        check_done("stalled", w0, 2);
        check("stalled_last_data", last_data, 32'h0810001F);
        pulse_rearm();

        // N = 0: 256 words, bytes = index[7:0].
        big = {};
        for (int i = 0; i < 1024; i++) big.push_back(8'(i));
        model_frame(big);
        check("model_w255", exp_q[255].data, 32'hFCFDFEFF);
        w0 = n_writes;
        send_frame(8'h00, big, 0);
        check_done("n0", w0, 256);
        check("n0_last_addr", last_addr, 32'h3FC);
        check("n0_last_data", last_data, 32'hFCFDFEFF);
        pulse_rearm();

        // Reset after 6 data bytes of a 2-word frame: only word 0 is written.
        model_frame(bytes_t'(prog[0:3]));
        w0 = n_writes;
        send_byte(START);
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) send_byte(prog[i]);
        @(negedge clk) reset = 1'b0;
        #1 check_reset_outputs("abort_in_reset");
        @(negedge clk) reset = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_reset_outputs("abort_released");
        check("abort_write_count", 32'(n_writes - w0), 32'd1);
        check("abort_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
